// File: rtl/imem_loader.sv
// imem_loader: loads instruction memory from a UART byte stream, then hands the address port to the PC
module imem_loader #(
  parameter int          DEPTH     = 32,
  parameter logic [7:0]  START_CMD = 8'h4C,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  input  logic [31:0] pc_addr,
  output logic [31:0] imem_addr,
  output logic        imem_wr,
  output logic [31:0] imem_wdata,
  output logic        pipe_en,
  output logic        load_done,
  output logic        overflow,
  output logic [31:0] word_count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [1:0] IDLE = 2'd0, RECV = 2'd1, WRITE = 2'd2, DONE = 2'd3;
  logic [1:0]    state;
  logic [AW-1:0] load_addr;
  logic [1:0]    byte_cnt;
  logic [31:0]   shreg;
  logic [31:0]   word;
  logic          start;
  logic          full;
  assign word      = {shreg[23:0], rx_data};
  assign start     = rx_valid && rx_data == START_CMD;
  assign full      = load_addr == AW'(DEPTH - 1);
  assign imem_addr = state == DONE ? pc_addr : 32'(load_addr);
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      load_addr  <= '0;
      byte_cnt   <= '0;
      shreg      <= '0;
      imem_wr    <= 1'b0;
      imem_wdata <= '0;
      pipe_en    <= 1'b0;
      load_done  <= 1'b0;
      overflow   <= 1'b0;
      word_count <= '0;
    end else begin
      imem_wr <= 1'b0;
      case (state)
        IDLE, DONE: if (start) begin
          state      <= RECV;
          load_addr  <= '0;
          byte_cnt   <= '0;
          word_count <= '0;
          overflow   <= 1'b0;
          load_done  <= 1'b0;
          pipe_en    <= 1'b0;
        end
        RECV: if (rx_valid) begin
          shreg    <= word;
          byte_cnt <= byte_cnt + 2'd1;
          if (byte_cnt == 2'd3) begin
            imem_wdata <= word;
            imem_wr    <= word != HALT_WORD;
            state      <= WRITE;
          end
        end
        WRITE: begin
          // a byte landing here starts the next word; it is lost if the load ends now
          if (rx_valid) begin
            shreg    <= word;
            byte_cnt <= 2'd1;
          end
          if (!imem_wr || full) begin
            state     <= DONE;
            pipe_en   <= 1'b1;
            load_done <= 1'b1;
          end else begin
            state     <= RECV;
            load_addr <= load_addr + AW'(1);
          end
          if (imem_wr) begin
            word_count <= word_count + 32'd1;
            overflow   <= full;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: byte-stream reference model and write scoreboard for imem_loader
module tb_imem_loader;
  localparam int DEPTH = 32;
  logic        clk = 1'b0, rst = 1'b1, rx_valid = 1'b0;
  logic [7:0]  rx_data = '0;
  logic [31:0] pc_addr = '0;
  logic [31:0] imem_addr, imem_wdata, word_count;
  logic        imem_wr, pipe_en, load_done, overflow;
  imem_loader dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data), .pc_addr(pc_addr),
    .imem_addr(imem_addr), .imem_wr(imem_wr), .imem_wdata(imem_wdata), .pipe_en(pipe_en),
    .load_done(load_done), .overflow(overflow), .word_count(word_count)
  );
  always #5 clk = ~clk;
  int checks = 0, failures = 0;
  logic [31:0] q_addr[$], q_data[$];
  bit          m_load, m_done, m_ovf;
  int          m_addr, m_cnt, m_bc;
  logic [31:0] m_word;
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, act, exp);
    end
  endtask
  task automatic model_reset();
    m_load = 0; m_done = 0; m_ovf = 0; m_addr = 0; m_cnt = 0; m_bc = 0; m_word = '0;
    q_addr.delete(); q_data.delete();
  endtask
  // a load is a sequence of 4-byte big-endian words after 'L', ending on the halt word or a full memory
  task automatic model_byte(input logic [7:0] b);
    if (!m_load) begin
      if (b == 8'h4C) begin
        m_load = 1; m_done = 0; m_ovf = 0; m_addr = 0; m_cnt = 0; m_bc = 0;
      end
    end else begin
      m_word = (m_word << 8) | 32'(b);
      m_bc++;
      if (m_bc == 4) begin
        m_bc = 0;
        if (m_word == 32'hFFFF_FFFF) begin
          m_load = 0; m_done = 1;
        end else begin
          q_addr.push_back(32'(m_addr)); q_data.push_back(m_word);
          m_cnt++;
          if (m_addr == DEPTH - 1) begin
            m_load = 0; m_done = 1; m_ovf = 1;
          end else m_addr++;
        end
      end
    end
  endtask
  task automatic tick();
    @(posedge clk); #1;
  endtask
  task automatic check_status();
    chk("load_done", load_done, m_done);
    chk("pipe_en", pipe_en, m_done);
    chk("overflow", overflow, m_ovf);
    chk("word_count", word_count, m_cnt);
    chk("imem_addr", imem_addr, m_done ? pc_addr : 32'(m_addr));
    chk("pending_writes", q_addr.size(), 0);
  endtask
  task automatic do_reset();
    rst = 1'b1; rx_valid = 1'b0; tick(); rst = 1'b0;
    model_reset();
  endtask
  task automatic chk_reset();
    chk("rst_wr", imem_wr, 0);
    chk("rst_wdata", imem_wdata, 0);
    chk("rst_pipe", pipe_en, 0);
    chk("rst_done", load_done, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_wc", word_count, 0);
    chk("rst_addr", imem_addr, 0);
  endtask
  task automatic send(input logic [7:0] b, input int gap);
    rx_valid = 1'b1; rx_data = b; tick(); rx_valid = 1'b0;
    model_byte(b);
    repeat (gap) tick();
    if (gap > 0) check_status();
  endtask
  task automatic send_word(input logic [31:0] w, input int gap);
    for (int i = 3; i >= 0; i--) send(w[8*i +: 8], gap);
  endtask
  always @(negedge clk) if (imem_wr) begin
    chk("wr_vs_pipe", pipe_en, 0);
    if (q_addr.size() == 0) chk("spurious_wr", imem_wr, 0);
    else begin
      chk("wr_addr", imem_addr, q_addr.pop_front());
      chk("wr_data", imem_wdata, q_data.pop_front());
    end
  end
  initial begin
    model_reset();
    tick(); tick(); rst = 1'b0;
    chk_reset();
    pc_addr = 32'd7;
    send(8'h11, 2); send(8'h22, 2);
    chk("t2_addr", imem_addr, 0);
    send(8'h4C, 1); send(8'h20, 1); send(8'h01, 1); send(8'h00, 1); send(8'h08, 2);
    chk("t1_wc", word_count, 1);
    send_word(32'hFFFF_FFFF, 2);
    chk("t1_done", load_done, 1); chk("t1_pipe", pipe_en, 1); chk("t1_ovf", overflow, 0);
    send(8'h4C, 1);
    for (int i = 0; i < DEPTH; i++) send_word(32'h1000 + i, 1);
    chk("t3_ovf", overflow, 1); chk("t3_done", load_done, 1); chk("t3_wc", word_count, DEPTH);
    send_word(32'h11223344, 1);
    pc_addr = 32'd5; tick();
    chk("t4_addr", imem_addr, 5);
    send(8'h4C, 1);
    chk("t4_pipe", pipe_en, 0); chk("t4_addr0", imem_addr, 0); chk("t4_wc", word_count, 0);
    send_word(32'hFFFF_FFFF, 2);
    send(8'h4C, 1); send(8'hAB, 1); send(8'hCD, 1);
    do_reset();
    chk_reset();
    send(8'h4C, 1); send_word(32'hDEADBEEF, 1); send_word(32'hFFFF_FFFF, 2);
    chk("t5_wc", word_count, 1);
    send(8'h4C, 2);
    send_word(32'hA1B2C3D4, 0); send_word(32'h0badf00d, 0); send_word(32'h12345678, 0);
    repeat (2) tick(); check_status();
    send_word(32'hFFFF_FFFF, 2);
    for (int n = 0; n < 25; n++) begin
      int words;
      pc_addr = $urandom;
      send(8'h4C, $urandom_range(1, 3));
      words = $urandom_range(0, 36);
      for (int w = 0; w < words; w++) begin
        logic [31:0] v;
        v = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
        if ($urandom_range(0, 40) == 0) begin do_reset(); chk_reset(); break; end
        send_word(v, $urandom_range(1, 3));
      end
      for (int j = 0; j < 3; j++) send(8'($urandom), $urandom_range(1, 2));
    end
    repeat (3) tick();
    check_status();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
